mc_control_fsm: RTL

//  Multicycle control state machine for the 16-bit datapath. Sequences fetch/decode/execute/memory/writeback,

---
 rtl/mc_control_fsm.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 16-bit datapath: sequences fetch/decode/execute/memory/writeback
// and decodes all datapath selects and enables from the current state.
module mc_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             ext_sel,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_ANDI  = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALTED   = 4'd12
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   halt_first;
  logic   zext_op;
  logic   illegal_op;

  // The zero flag qualifies pc_write_cond inside the datapath; the FSM never branches on it.
  logic unused_zero;
  assign unused_zero = zero;

  assign zext_op    = (opcode == OP_ORI) || (opcode == OP_ANDI);
  assign illegal_op = (opcode >= 4'h8) && (opcode <= 4'hE);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                 state_nxt = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI: state_nxt = S_EXEC_I;
          OP_LW, OP_SW:             state_nxt = S_MEM_ADDR;
          OP_BEQ:                   state_nxt = S_BRANCH;
          OP_JMP:                   state_nxt = S_JUMP;
          default:                  state_nxt = S_HALTED;
        endcase
      end
      S_EXEC_R:   state_nxt = S_ALU_WB;
      S_EXEC_I:   state_nxt = S_ALU_WB;
      S_ALU_WB:   state_nxt = S_FETCH;
      S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_HALTED:   if (start) state_nxt = S_FETCH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Datapath control decode; depends on the state register so async reset clears every enable at once
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    ext_sel       = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        ext_sel   = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_sel   = ~zext_op;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        ext_sel   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sel   = ~zext_op;
        case (opcode)
          OP_ORI:  alu_op = ALU_OR;
          OP_ANDI: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        instr_done = 1'b1;
        ext_sel    = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_sel   = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        ext_sel  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        ext_sel    = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        ext_sel    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        instr_done    = 1'b1;
        ext_sel       = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
        ext_sel    = 1'b1;
      end
      S_HALTED: begin
        instr_done = halt_first;
        ext_sel    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      halt_first <= 1'b0;
      illegal    <= 1'b0;
      instr_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      // HALT retires in its first HALTED cycle only; illegal opcodes never retire
      halt_first <= (state == S_DECODE) && (opcode == OP_HALT);
      if ((state == S_DECODE) && illegal_op) begin
        illegal <= 1'b1;
      end else if ((state == S_HALTED) && start) begin
        illegal <= 1'b0;
      end
      if (instr_done) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

endmodule
